// File: rtl/seq_mul_pkg.sv
// rtl/seq_mul_pkg.sv - shared FSM state type for the shift-add multiplier
package seq_mul_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

endpackage

// File: rtl/seq_shift_add_mul.sv
// rtl/seq_shift_add_mul.sv - sequential unsigned shift-add multiplier with valid/ready handshakes
// Optional SEQ_MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module seq_shift_add_mul
  import seq_mul_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  mul_state_t         state;
  mul_state_t         state_nx;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;

  logic [2*WIDTH-1:0] acc_add;
  logic [WIDTH-1:0]   mplier_sh;
  logic               last_step;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    acc_add   = mplier[0] ? (acc + mcand) : acc;
    mplier_sh = mplier >> 1;
    last_step = (cnt == CNT_W'(WIDTH - 1));
`ifdef SEQ_MUL_EARLY_EXIT_EN
    last_step = last_step || (mplier_sh == '0);
`endif
    state_nx = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
`ifdef SEQ_MUL_EARLY_EXIT_EN
          state_nx = (b == '0) ? DONE : BUSY;
`else
          state_nx = BUSY;
`endif
        end
      end
      BUSY:    state_nx = last_step ? DONE : BUSY;
      DONE:    state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= '0;
`ifdef SEQ_MUL_EARLY_EXIT_EN
            if (b == '0) product <= '0;
`endif
          end
        end
        BUSY: begin
          acc    <= acc_add;
          mcand  <= mcand << 1;
          mplier <= mplier_sh;
          cnt    <= cnt + CNT_W'(1);
          // product takes the accumulate that includes this edge's partial product
          if (last_step) product <= acc_add;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// tb/tb_seq_shift_add_mul.sv - self-checking bench for seq_shift_add_mul (WIDTH=8)
module tb_seq_shift_add_mul;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;

  int errors = 0;
  int checks = 0;

  seq_shift_add_mul #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   va;
    logic [W-1:0]   vb;
    logic [2*W-1:0] exp_p;
    int             lat_fixed;
    int             lat_early;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference latency: edges from accept to DONE, derived from the operand alone
  function automatic int model_lat(input logic [W-1:0] mb);
`ifdef SEQ_MUL_EARLY_EXIT_EN
    return $clog2(int'(mb) + 1);
`else
    return W;
`endif
  endfunction

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [2*W-1:0] exp_p,
                       input int exp_lat, input int bp, input string nm);
    int lat;
    logic [2*W-1:0] held;
    @(negedge clk);
    a = ta; b = tb; in_valid = 1'b1;
    chk({nm, " in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, " product"}, 64'(product), 64'(exp_p));
    held = product;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      chk({nm, " bp out_valid"}, 64'(out_valid), 64'd1);
      chk({nm, " bp product"}, 64'(product), 64'(held));
      chk({nm, " bp in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, " post out_valid"}, 64'(out_valid), 64'd0);
    chk({nm, " post in_ready"}, 64'(in_ready), 64'd1);
    chk({nm, " post product hold"}, 64'(product), 64'(exp_p));
  endtask

  vec_t vecs[7];

  initial begin
    int lat;
    logic [W-1:0] ra, rb;

    vecs[0] = '{8'd3,   8'd5,   16'd15,    8, 3};
    vecs[1] = '{8'hFF,  8'hFF,  16'hFE01,  8, 8};
    vecs[2] = '{8'd0,   8'd5,   16'd0,     8, 3};
    vecs[3] = '{8'd7,   8'd0,   16'd0,     8, 0};
    vecs[4] = '{8'd1,   8'd1,   16'd1,     8, 1};
    vecs[5] = '{8'h80,  8'h80,  16'h4000,  8, 8};
    vecs[6] = '{8'hFF,  8'd1,   16'h00FF,  8, 1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset product", 64'(product), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
`ifdef SEQ_MUL_EARLY_EXIT_EN
      do_op(vecs[i].va, vecs[i].vb, vecs[i].exp_p, vecs[i].lat_early, 0, $sformatf("vec%0d", i));
`else
      do_op(vecs[i].va, vecs[i].vb, vecs[i].exp_p, vecs[i].lat_fixed, 0, $sformatf("vec%0d", i));
`endif
    end

    do_op(8'd3, 8'd5, 16'd15, model_lat(8'd5), 5, "backpressure");

    // Operand pulse while busy must be ignored, and no second result appears
    @(negedge clk);
    a = 8'd3; b = 8'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    a = 8'd7; b = 8'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ignore latency", 64'(lat), 64'(model_lat(8'd5)));
    chk("ignore product", 64'(product), 64'd15);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("ignore no 2nd out_valid", 64'(out_valid), 64'd0);
      chk("ignore idle in_ready", 64'(in_ready), 64'd1);
    end

    // Asynchronous reset mid-BUSY drops the operation
    @(negedge clk);
    a = 8'hAB; b = 8'hC5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset out_valid", 64'(out_valid), 64'd0);
    chk("midreset in_ready", 64'(in_ready), 64'd1);
    chk("midreset product", 64'(product), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'd2, 8'd2, 16'd4, model_lat(8'd2), 0, "after reset");

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      if (i % 8 == 0) rb = '0;
      do_op(ra, rb, 16'(int'(ra) * int'(rb)), model_lat(rb), int'($urandom_range(0, 3)),
            $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
